// File: rtl/romulus_config_pkg.sv
// Shared configuration for the Romulus LWC wrapper: core bus width and
// the recommended sizing of the public-data input buffer.
package romulus_config_pkg;

  localparam int BUSW = 32;

  localparam int PDI_FIFO_DEPTH = 8;

  // Pointer width for a power-of-two buffer depth; never less than one bit.
  function automatic int fifo_addr_width(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) w = 1;
    return w;
  endfunction

  localparam int PDI_FIFO_ADDRW = fifo_addr_width(PDI_FIFO_DEPTH);

endpackage

// File: rtl/lwc_fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module lwc_fifo_mem #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  parameter int ADDRW = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lwc_pdi_fifo.sv
// First-word fall-through elastic buffer feeding the LWC core's pdi port.
// Fullness comes from the level counter, so pointers simply wrap.
module lwc_pdi_fifo #(
  parameter int BUSW  = romulus_config_pkg::BUSW,
  parameter int DEPTH = romulus_config_pkg::PDI_FIFO_DEPTH,
  parameter int ADDRW = romulus_config_pkg::fifo_addr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BUSW-1:0] in_data,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BUSW-1:0] out_data,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ADDRW:0]  level
);

  localparam logic [ADDRW-1:0] PTR_ONE    = ADDRW'(1);
  localparam logic [ADDRW:0]   LVL_ONE    = (ADDRW+1)'(1);
  localparam logic [ADDRW:0]   FULL_LEVEL = (ADDRW+1)'(DEPTH);

  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic [BUSW:0]    rd_word;
  logic             push;
  logic             pop;

  // Handshake flags depend only on registered level, never on the opposite side.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  lwc_fifo_mem #(
    .WIDTH (BUSW + 1),
    .DEPTH (DEPTH),
    .ADDRW (ADDRW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_last, in_data}),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  // The head is forced to zero while empty so stale array contents never leak out.
  assign out_data = out_valid ? rd_word[BUSW-1:0] : '0;
  assign out_last = out_valid ? rd_word[BUSW]     : 1'b0;

endmodule

// File: tb/tb_lwc_pdi_fifo.sv
// Directed scenarios plus randomized traffic against a queue-based model of the buffer.
module tb_lwc_pdi_fifo;

  localparam int W = 32;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    level;

  int checks = 0;
  int failures = 0;

  logic [W:0] model_q [$];

  lwc_pdi_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordinary queue, capacity D.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (model_q.size() < D);
      do_pop  = out_ready && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({in_last, in_data});
    end
  end

  always @(negedge clk) begin
    logic [W:0] head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    chk("cyc_level", 64'(level), 64'(model_q.size()));
    chk("cyc_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    chk("cyc_in_ready", 64'(in_ready), 64'(model_q.size() != D));
    chk("cyc_out_data", 64'(out_data), 64'(head[W-1:0]));
    chk("cyc_out_last", 64'(out_last), 64'(head[W]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [W-1:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + W'(i);
      in_last  = 1'b0;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset pulsed mid-cycle, then idle with out_ready high
    step();
    push_n(3, 32'h77);
    chk("t1_pre_level", 64'(level), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_valid", 64'(out_valid), 64'd0);
    chk("t1_rst_ready", 64'(in_ready), 64'd1);
    chk("t1_rst_level", 64'(level), 64'd0);
    chk("t1_rst_data", 64'(out_data), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("t1_idle_level", 64'(level), 64'd0);
    chk("t1_idle_valid", 64'(out_valid), 64'd0);
    idle();

    // 2: fill to full, extra word dropped, drain in order
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      in_last  = (i == 8);
      step();
    end
    chk("t2_full_level", 64'(level), 64'd8);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    in_data = 32'hDEADBEEF;
    in_last = 1'b0;
    step();
    chk("t2_drop_level", 64'(level), 64'd8);
    chk("t2_drop_head", 64'(out_data), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain_data", 64'(out_data), 64'(i));
      chk("t2_drain_last", 64'(out_last), 64'(i == 8));
      step();
    end
    chk("t2_empty_level", 64'(level), 64'd0);
    idle();

    // 3: streaming, one word per cycle with one cycle of latency
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'hA0 + W'(i);
      step();
      chk("t3_level", 64'(level), 64'd1);
      chk("t3_head", 64'(out_data), 64'(32'hA0 + i));
    end
    in_valid = 1'b0;
    step();
    chk("t3_end_level", 64'(level), 64'd0);
    idle();

    // 4: wrap-around of both pointers
    push_n(5, 32'h300);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    push_n(6, 32'h10);
    chk("t4_level", 64'(level), 64'd6);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t4_order", 64'(out_data), 64'(32'h10 + i));
      step();
    end
    idle();

    // 5: full with simultaneous pop; push refused that cycle
    push_n(8, 32'h500);
    chk("t5_full", 64'(level), 64'd8);
    in_valid  = 1'b1;
    in_data   = 32'hBAD0;
    out_ready = 1'b1;
    step();
    idle();
    chk("t5_level", 64'(level), 64'd7);
    chk("t5_ready", 64'(in_ready), 64'd1);
    chk("t5_head", 64'(out_data), 64'h501);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("t5_drained", 64'(level), 64'd0);
    idle();

    // 6: reset mid-burst, then the first new word becomes head
    push_n(5, 32'h600);
    chk("t6_level5", 64'(level), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h55;
    step();
    in_valid = 1'b0;
    chk("t6_head", 64'(out_data), 64'h55);
    chk("t6_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    idle();

    // Randomized traffic with varying pressure on both sides
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      in_valid  = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5)));
      out_ready = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5)));
      in_data   = $urandom;
      in_last   = $urandom_range(0, 1);
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
